// File: rtl/ram_burst_initiator_if.sv
// ram_burst_initiator_if: command, write/read stream and RAM port bundle.
// ACsum exists only when RAM_BURST_CSUM_EN is defined.
interface ram_burst_initiator_if #(parameter int caddrlen = 8);
  logic acmdstart, acmdwr, acmdbusy, acmddone;
  logic [caddrlen-1:0] acmdaddr, aaddrwr, aaddrrd;
  logic [7:0] acmdlen, awrdata, arddata, amosi, amiso;
  logic awrvalid, awrready, ardvalid, ardready, awren;
`ifdef RAM_BURST_CSUM_EN
  logic [7:0] acsum;
  modport master(
    input acmdstart, acmdwr, acmdaddr, acmdlen, awrdata, awrvalid, ardready, amiso,
    output acmdbusy, acmddone, awrready, arddata, ardvalid, aaddrwr, aaddrrd, amosi, awren, acsum
  );
  modport slave(
    output acmdstart, acmdwr, acmdaddr, acmdlen, awrdata, awrvalid, ardready, amiso,
    input acmdbusy, acmddone, awrready, arddata, ardvalid, aaddrwr, aaddrrd, amosi, awren, acsum
  );
`else
  modport master(
    input acmdstart, acmdwr, acmdaddr, acmdlen, awrdata, awrvalid, ardready, amiso,
    output acmdbusy, acmddone, awrready, arddata, ardvalid, aaddrwr, aaddrrd, amosi, awren
  );
  modport slave(
    output acmdstart, acmdwr, acmdaddr, acmdlen, awrdata, awrvalid, ardready, amiso,
    input acmdbusy, acmddone, awrready, arddata, ardvalid, aaddrwr, aaddrrd, amosi, awren
  );
`endif
endinterface

// File: rtl/ram_burst_initiator.sv
// ram_burst_initiator: turns one host command into a burst of byte writes or reads on a RAM port.
// RAM_BURST_CSUM_EN adds ACsum, the modulo-256 sum of the bytes moved by the current burst.
module ram_burst_initiator #(
  parameter int crdlat = 1,
  parameter int caddrlen = 8
) (
  input logic aclkh,
  input logic areseth,
  input logic aclkhen,
  ram_burst_initiator_if.master b
);
  typedef enum logic [2:0] {st_idle, st_wr, st_rd_iss, st_rd_wait, st_rd_hold, st_done} state_t;
  state_t state, nxt;
  logic [caddrlen-1:0] addr, addr_rd;
  logic [7:0] cnt, rd_data;
  logic [1:0] lat;
  logic rd_valid, start, beat, hs;
  assign start = state == st_idle && b.acmdstart && aclkhen;
  assign beat = state == st_wr && b.awrvalid && aclkhen;
  assign hs = state == st_rd_hold && b.ardready && aclkhen;
  assign b.acmdbusy = state != st_idle;
  assign b.acmddone = state == st_done;
  // ready is withheld while the clock enable is low so no beat is offered that cannot be taken
  assign b.awrready = state == st_wr && aclkhen;
  assign b.awren = beat;
  assign b.aaddrwr = beat ? addr : '0;
  assign b.amosi = beat ? b.awrdata : '0;
  // the issue cycle presents the address directly; the register keeps it until the next issue
  assign b.aaddrrd = state == st_rd_iss ? addr : addr_rd;
  assign b.arddata = rd_data;
  assign b.ardvalid = rd_valid;
  always_ff @(posedge aclkh or posedge areseth)
    if (areseth) state <= st_idle;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (aclkhen)
      case (state)
        st_idle: nxt = b.acmdstart ? (b.acmdwr ? st_wr : st_rd_iss) : st_idle;
        st_wr: nxt = beat && cnt == '0 ? st_done : st_wr;
        st_rd_iss: nxt = st_rd_wait;
        st_rd_wait: nxt = lat == '0 ? st_rd_hold : st_rd_wait;
        st_rd_hold: nxt = hs ? (cnt == '0 ? st_done : st_rd_iss) : st_rd_hold;
        default: nxt = st_idle;
      endcase
  end
  always_ff @(posedge aclkh or posedge areseth)
    if (areseth) begin
      addr <= '0;
      cnt <= '0;
      lat <= '0;
      addr_rd <= '0;
      rd_data <= '0;
      rd_valid <= 1'b0;
    end else if (aclkhen) begin
      if (start) begin
        addr <= b.acmdaddr;
        cnt <= b.acmdlen;
      end
      if (beat || hs) begin
        addr <= addr + caddrlen'(1);
        cnt <= cnt - 8'd1;
      end
      if (state == st_rd_iss) begin
        addr_rd <= addr;
        lat <= 2'(crdlat - 1);
      end
      if (state == st_rd_wait) lat <= lat - 2'd1;
      if (state == st_rd_wait && lat == '0) begin
        rd_data <= b.amiso;
        rd_valid <= 1'b1;
      end
      if (hs) rd_valid <= 1'b0;
    end
`ifdef RAM_BURST_CSUM_EN
  logic [7:0] csum;
  assign b.acsum = csum;
  always_ff @(posedge aclkh or posedge areseth)
    if (areseth) csum <= '0;
    else if (start) csum <= '0;
    else if (beat) csum <= csum + b.awrdata;
    else if (hs) csum <= csum + rd_data;
`endif
endmodule

// File: tb/tb_ram_burst_initiator.sv
// tb_ram_burst_initiator: directed bursts checked against a transaction-level model every cycle.
module tb_ram_burst_initiator;
  logic aclkh = 1'b0, areseth = 1'b1, aclkhen = 1'b1;
  ram_burst_initiator_if b();
  ram_burst_initiator dut(.aclkh(aclkh), .areseth(areseth), .aclkhen(aclkhen), .b(b));
  always #5 aclkh = ~aclkh;

  int total = 0, bad = 0, cyc = 0, start_cnt = 0, done_cnt = 0, done_t = 0;
  bit pend = 0, mwr = 0;
  logic [7:0] ram[256];
  bit ram_v[256];
  logic [7:0] mm[256];
  bit mm_v[256];
  logic [7:0] exp_a[$], exp_d[$], wlog[$], rlog[$], rdat[$];
  int wtime[$], rtime[$];

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  function automatic logic [7:0] mval(logic [7:0] a);
    return mm_v[a] ? mm[a] : a ^ 8'h5A;
  endfunction

  // RAM environment: synchronous write, one-cycle read latency; unwritten bytes read addr^0x5A
  always @(posedge aclkh) begin
    if (b.awren) begin
      ram[b.aaddrwr] <= b.amosi;
      ram_v[b.aaddrwr] <= 1'b1;
    end
    b.amiso <= ram_v[b.aaddrrd] ? ram[b.aaddrrd] : b.aaddrrd ^ 8'h5A;
  end

  // model: each accepted command owes len+1 beats at consecutive addresses, done follows the last
  always @(negedge aclkh) begin
    cyc++;
    if (areseth) begin
      exp_a.delete();
      exp_d.delete();
      pend = 0;
      done_cnt = start_cnt;
    end else begin
      chk("busy", b.acmdbusy, start_cnt != done_cnt);
      chk("done", b.acmddone, pend);
      if (pend && aclkhen) begin
        pend = 0;
        done_cnt++;
        done_t = cyc;
      end
      chk("awren", b.awren, mwr && exp_a.size() != 0 && b.awrvalid && aclkhen);
      if (b.awren && exp_a.size() != 0 && exp_d.size() != 0) begin
        chk("aaddrwr", b.aaddrwr, exp_a[0]);
        chk("amosi", b.amosi, exp_d[0]);
        mm[exp_a[0]] = exp_d[0];
        mm_v[exp_a[0]] = 1;
        wlog.push_back(b.aaddrwr);
        wtime.push_back(cyc);
        void'(exp_a.pop_front());
        void'(exp_d.pop_front());
        pend = exp_a.size() == 0;
      end
      if (!mwr && b.ardvalid && b.ardready && aclkhen) begin
        if (exp_a.size() == 0) chk("rd_extra", 1, 0);
        else begin
          chk("aaddrrd", b.aaddrrd, exp_a[0]);
          chk("arddata", b.arddata, mval(exp_a[0]));
          rlog.push_back(b.aaddrrd);
          rdat.push_back(b.arddata);
          rtime.push_back(cyc);
          void'(exp_a.pop_front());
          pend = exp_a.size() == 0;
        end
      end
    end
  end

  task automatic cmd(bit wr, logic [7:0] a, logic [7:0] len);
    bit idle;
    idle = start_cnt == done_cnt;
    b.acmdstart = 1;
    b.acmdwr = wr;
    b.acmdaddr = a;
    b.acmdlen = len;
    @(posedge aclkh); #1;
    b.acmdstart = 0;
    if (idle && aclkhen) begin
      start_cnt++;
      mwr = wr;
      wlog.delete(); rlog.delete(); rdat.delete(); wtime.delete(); rtime.delete();
      for (int i = 0; i <= int'(len); i++) exp_a.push_back(a + 8'(i));
    end
  endtask

  task automatic wbeat(logic [7:0] d);
    bit hit;
    hit = 0;
    b.awrdata = d;
    b.awrvalid = 1;
    exp_d.push_back(d);
    for (int n = 0; n < 20 && !hit; n++) begin
      @(negedge aclkh);
      hit = b.awrready && aclkhen;
      @(posedge aclkh); #1;
    end
    if (!hit) chk("wr_timeout", 0, 1);
  endtask

  task automatic wait_done(int budget);
    int n;
    n = 0;
    while (start_cnt != done_cnt && n < budget) begin
      @(posedge aclkh); #1;
      n++;
    end
    chk("done_timeout", start_cnt != done_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [7:0] d, a;
    bit seen;
    b.acmdstart = 0; b.acmdwr = 0; b.acmdaddr = 0; b.acmdlen = 0;
    b.awrdata = 0; b.awrvalid = 0; b.ardready = 1;
    repeat (2) @(posedge aclkh);
    #1;
    chk("rst_busy", b.acmdbusy, 0);
    chk("rst_awren", b.awren, 0);
    chk("rst_awrready", b.awrready, 0);
    chk("rst_ardvalid", b.ardvalid, 0);
    chk("rst_aaddrrd", b.aaddrrd, 0);
    chk("rst_arddata", b.arddata, 0);
    areseth = 0;
    @(posedge aclkh); #1;
    // write burst 0x10..0x13, valid every cycle
    cmd(1, 8'h10, 8'd3);
    wbeat(8'hA1); wbeat(8'hA2); wbeat(8'hA3); wbeat(8'hA4);
    b.awrvalid = 0;
    wait_done(20);
    chk("wr_beats", wlog.size(), 4);
    chk("wr_first", wlog[0], 8'h10);
    chk("wr_last", wlog[3], 8'h13);
    chk("wr_back2back", wtime[3] - wtime[0], 3);
    chk("wr_done_lat", done_t - wtime[3], 1);
`ifdef RAM_BURST_CSUM_EN
    chk("csum_wr", b.acsum, 8'h8A);
`endif
    // read-back, one beat every three cycles
    cmd(0, 8'h10, 8'd3);
    wait_done(40);
    chk("rd_beats", rdat.size(), 4);
    chk("rd_d0", rdat[0], 8'hA1);
    chk("rd_d3", rdat[3], 8'hA4);
    chk("rd_pace01", rtime[1] - rtime[0], 3);
    chk("rd_pace23", rtime[3] - rtime[2], 3);
    chk("rd_done_lat", done_t - rtime[3], 1);
`ifdef RAM_BURST_CSUM_EN
    chk("csum_rd", b.acsum, 8'h8A);
`endif
    // address wrap
    cmd(0, 8'hFE, 8'd2);
    wait_done(40);
    chk("wrap0", rlog[0], 8'hFE);
    chk("wrap1", rlog[1], 8'hFF);
    chk("wrap2", rlog[2], 8'h00);
    chk("wrap_d2", rdat[2], 8'h5A);
    // read backpressure then clock-enable freeze
    cmd(0, 8'h10, 8'd1);
    b.ardready = 0;
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge aclkh);
      seen = b.ardvalid;
    end
    chk("bp_valid_seen", seen, 1);
    d = b.arddata;
    a = b.aaddrrd;
    chk("bp_data", d, 8'hA1);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclkh);
      chk("bp_ardvalid", b.ardvalid, 1);
      chk("bp_arddata", b.arddata, d);
      chk("bp_aaddrrd", b.aaddrrd, a);
    end
    @(posedge aclkh); #1;
    aclkhen = 0;
    b.ardready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclkh);
      chk("frz_ardvalid", b.ardvalid, 1);
      chk("frz_arddata", b.arddata, d);
      chk("frz_aaddrrd", b.aaddrrd, a);
      chk("frz_busy", b.acmdbusy, 1);
      @(posedge aclkh); #1;
    end
    aclkhen = 1;
    wait_done(40);
    chk("bp_beats", rdat.size(), 2);
    // write valid toggling 1,0,1
    cmd(1, 8'h30, 8'd2);
    wbeat(8'hB1);
    b.awrvalid = 0;
    @(negedge aclkh);
    chk("gap_awren", b.awren, 0);
    @(posedge aclkh); #1;
    wbeat(8'hB2); wbeat(8'hB3);
    b.awrvalid = 0;
    wait_done(20);
    chk("gap_spacing", wtime[1] - wtime[0], 2);
    chk("gap_last", wlog[2], 8'h32);
    // reset during the second beat of a four-beat write
    cmd(1, 8'h50, 8'd3);
    wbeat(8'hC1);
    b.awrdata = 8'hC2;
    b.awrvalid = 1;
    #2;
    areseth = 1;
    #1;
    chk("mid_rst_awren", b.awren, 0);
    chk("mid_rst_busy", b.acmdbusy, 0);
    chk("mid_rst_done", b.acmddone, 0);
    b.awrvalid = 0;
    @(posedge aclkh); #1;
    @(posedge aclkh); #1;
    areseth = 0;
    cmd(1, 8'h60, 8'd1);
    wbeat(8'hD1); wbeat(8'hD2);
    b.awrvalid = 0;
    wait_done(20);
    chk("post_rst_first", wlog[0], 8'h60);
    chk("post_rst_beats", wlog.size(), 2);
    // start pulsed while busy is ignored
    cmd(1, 8'h70, 8'd1);
    wbeat(8'hE1);
    b.awrvalid = 0;
    b.acmdstart = 1; b.acmdwr = 0; b.acmdaddr = 8'h80; b.acmdlen = 8'd5;
    @(posedge aclkh); #1;
    b.acmdstart = 0;
    wbeat(8'hE2);
    b.awrvalid = 0;
    wait_done(20);
    chk("ign_beats", wlog.size(), 2);
    chk("ign_last", wlog[1], 8'h71);
    @(negedge aclkh);
    chk("ign_idle", b.acmdbusy, 0);
    // aborted beat left 0x51 untouched
    @(posedge aclkh); #1;
    cmd(0, 8'h4F, 8'd2);
    wait_done(40);
    chk("abort_d0", rdat[0], 8'h15);
    chk("abort_d1", rdat[1], 8'hC1);
    chk("abort_d2", rdat[2], 8'h0B);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
